hit_buffer: RTL and testbench

- Elastic FIFO directly downstream of the sample-test stage, in front of the z-buffer/frame-buffer writer.
- Captures every hit sample (position plus color) from the rasterizer pipeline.
- Presents hits one at a time on a valid/ready interface.
- Raises a registered halt back up the pipeline early enough that in-flight hits from the iterator, hash and sample stages never overflow it.

---
 rtl/hit_buffer.sv | 112 +++++++++++
 tb/tb_hit_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hit_buffer.sv
// hit_buffer: elastic FIFO between the sample-test stage and the
// z-buffer/frame-buffer writer. Captures every hit sample (position plus
// color) and presents hits one at a time on a valid/ready interface with
// show-ahead output. A registered halt asks upstream to stop early enough
// that SLACK in-flight hits still fit.
//
// Ports:
//   clk           in   clock, all logic on rising edge
//   rst           in   synchronous active-high reset, discards buffered hits
//   hit_valid_in  in   hit qualifier, at most one hit per cycle
//   hit_sample_in in   hit position {z,y,x}, x in LSBs
//   hit_color_in  in   hit color {b,g,r}, r in LSBs
//   halt_out      out  registered stall request to upstream (1 = stop)
//   out_valid     out  head entry is valid
//   out_ready     in   consumer accepts head this cycle
//   out_sample    out  head position
//   out_color     out  head color
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky: a hit was dropped because the FIFO was full
module hit_buffer #(
    parameter int SIGFIG = 24,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int DEPTH  = 16,
    parameter int SLACK  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hit_valid_in,
    input  logic [AXIS*SIGFIG-1:0]     hit_sample_in,
    input  logic [COLORS*SIGFIG-1:0]   hit_color_in,
    output logic                       halt_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [AXIS*SIGFIG-1:0]     out_sample,
    output logic [COLORS*SIGFIG-1:0]   out_color,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int SW = AXIS * SIGFIG;
    localparam int CLW = COLORS * SIGFIG;
    localparam int EW = SW + CLW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH = CW'(DEPTH - SLACK);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_halt;
    logic          r_overflow;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    logic [EW-1:0] w_head;

    assign w_pop  = (r_count != '0) && out_ready;
    // At full, a same-cycle pop frees the slot being written.
    assign w_push = hit_valid_in && ((r_count < FULL) || w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Storage is not reset; contents are meaningless while count == 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {hit_sample_in, hit_color_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_halt     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            // Registered so out_ready has no combinational path to halt_out.
            r_halt  <= (w_count_next >= THRESH);
            if (hit_valid_in && (r_count == FULL) && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign out_valid  = (r_count != '0);
    assign out_sample = w_head[EW-1:CLW];
    assign out_color  = w_head[CLW-1:0];
    assign count      = r_count;
    assign halt_out   = r_halt;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_hit_buffer.sv
module tb_hit_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        hit_valid_in;
    logic [71:0] hit_sample_in;
    logic [71:0] hit_color_in;
    logic        halt_out;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_sample;
    logic [71:0] out_color;
    logic [4:0]  count;
    logic        overflow;

    hit_buffer #(
        .SIGFIG(24),
        .AXIS(3),
        .COLORS(3),
        .DEPTH(16),
        .SLACK(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hit_valid_in(hit_valid_in),
        .hit_sample_in(hit_sample_in),
        .hit_color_in(hit_color_in),
        .halt_out(halt_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sample(out_sample),
        .out_color(out_color),
        .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference model state
    int          m_count = 0;
    logic        m_halt = 1'b0;
    logic        m_ovf = 1'b0;
    logic [71:0] q_s[$];
    logic [71:0] q_c[$];
    logic [4:0]  hist = '0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge from current inputs, advance, then compare.
    task automatic cycle();
        logic        pop, push, pv, pr, prst;
        logic [71:0] ps, pc;
        pop  = (m_count != 0) && out_ready;
        push = hit_valid_in && ((m_count < 16) || pop);
        pv = out_valid; pr = out_ready; prst = rst; ps = out_sample; pc = out_color;
        if (rst) begin
            m_count = 0; m_halt = 1'b0; m_ovf = 1'b0;
            q_s.delete(); q_c.delete();
        end else begin
            if (pop) begin
                chk("pop_sample", out_sample, q_s[0]);
                chk("pop_color", out_color, q_c[0]);
                void'(q_s.pop_front());
                void'(q_c.pop_front());
            end
            if (hit_valid_in && (m_count == 16) && !pop) m_ovf = 1'b1;
            if (push) begin
                q_s.push_back(hit_sample_in);
                q_c.push_back(hit_color_in);
            end
            m_count = m_count + int'(push) - int'(pop);
            m_halt = (m_count >= 12);
        end
        @(posedge clk);
        #1;
        hist = {hist[3:0], halt_out};
        chk("count", 72'(count), 72'(m_count));
        chk("count_le_depth", 72'(count <= 5'd16), 72'(1));
        chk("out_valid", 72'(out_valid), 72'(m_count != 0));
        chk("halt_out", 72'(halt_out), 72'(m_halt));
        chk("overflow", 72'(overflow), 72'(m_ovf));
        if (pv && !pr && !prst) begin
            chk("stable_sample", out_sample, ps);
            chk("stable_color", out_color, pc);
        end
    endtask

    initial begin
        rst = 1'b1; hit_valid_in = 1'b0; out_ready = 1'b0;
        hit_sample_in = '0; hit_color_in = '0;
        #1;
        cycle(); cycle();
        rst = 1'b0;
        cycle(); cycle();
        chk("rst_count", 72'(count), 72'(0));
        chk("rst_valid", 72'(out_valid), 72'(0));
        chk("rst_halt", 72'(halt_out), 72'(0));
        chk("rst_ovf", 72'(overflow), 72'(0));

        // Three hits with consumer always ready
        out_ready = 1'b1;
        hit_valid_in = 1'b1; hit_sample_in = 72'h1; hit_color_in = 72'h10;
        chk("no_bypass", 72'(out_valid), 72'(0));
        cycle();
        chk("first_valid", 72'(out_valid), 72'(1));
        chk("head1", out_sample, 72'h1);
        chk("head1_col", out_color, 72'h10);
        hit_sample_in = 72'h2; hit_color_in = 72'h20;
        cycle();
        chk("head2", out_sample, 72'h2);
        chk("cnt_push_pop", 72'(count), 72'(1));
        hit_sample_in = 72'h3; hit_color_in = 72'h30;
        cycle();
        chk("head3", out_sample, 72'h3);
        chk("head3_col", out_color, 72'h30);
        hit_valid_in = 1'b0;
        cycle();
        chk("empty_again", 72'(count), 72'(0));
        chk("empty_valid", 72'(out_valid), 72'(0));

        // Fill with consumer stalled: halt appears with the 12th push
        out_ready = 1'b0;
        hit_valid_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            hit_sample_in = 72'(32'h100 + i); hit_color_in = 72'(32'h200 + i);
            cycle();
            chk("fill_halt", 72'(halt_out), 72'(i >= 11));
        end
        chk("cnt12", 72'(count), 72'(12));
        for (int i = 12; i < 16; i++) begin
            hit_sample_in = 72'(32'h100 + i); hit_color_in = 72'(32'h200 + i);
            cycle();
        end
        chk("cnt16", 72'(count), 72'(16));
        chk("no_ovf_at_full", 72'(overflow), 72'(0));

        // 17th hit dropped
        hit_sample_in = 72'hdead; hit_color_in = 72'hbeef;
        cycle();
        chk("drop_ovf", 72'(overflow), 72'(1));
        chk("drop_cnt", 72'(count), 72'(16));
        hit_valid_in = 1'b0;
        cycle();
        chk("ovf_sticky", 72'(overflow), 72'(1));

        // Drain in original order
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_head", out_sample, 72'(32'h100 + i));
            chk("drain_col", out_color, 72'(32'h200 + i));
            cycle();
            chk("drain_halt", 72'(halt_out), 72'((15 - i) >= 12));
        end
        chk("drained", 72'(count), 72'(0));
        chk("ovf_after_drain", 72'(overflow), 72'(1));

        // Mid-stream reset at count 7, with a hit arriving on the same edge
        out_ready = 1'b0; hit_valid_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            hit_sample_in = 72'(32'h400 + i); hit_color_in = 72'(32'h500 + i);
            cycle();
        end
        chk("cnt7", 72'(count), 72'(7));
        rst = 1'b1;
        cycle();
        rst = 1'b0; hit_valid_in = 1'b0;
        chk("mid_rst_cnt", 72'(count), 72'(0));
        chk("mid_rst_valid", 72'(out_valid), 72'(0));
        chk("mid_rst_ovf", 72'(overflow), 72'(0));

        // Full with simultaneous push/pop across pointer wrap
        hit_valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            hit_sample_in = 72'(32'h600 + i); hit_color_in = 72'(32'h700 + i);
            cycle();
        end
        chk("wrap_full", 72'(count), 72'(16));
        out_ready = 1'b1;
        for (int i = 16; i < 56; i++) begin
            chk("wrap_head", out_sample, 72'(32'h600 + i - 16));
            hit_sample_in = 72'(32'h600 + i); hit_color_in = 72'(32'h700 + i);
            cycle();
            chk("wrap_cnt", 72'(count), 72'(16));
        end
        chk("wrap_no_ovf", 72'(overflow), 72'(0));
        hit_valid_in = 1'b0;
        for (int i = 0; i < 16; i++) cycle();
        chk("wrap_drained", 72'(count), 72'(0));

        // Random traffic, upstream stops issuing 4 cycles after halt
        hist = '0;
        for (int i = 0; i < 10000; i++) begin
            hit_valid_in  = !hist[4] && ($urandom_range(1) == 1);
            hit_sample_in = 72'({$urandom(), $urandom(), $urandom()});
            hit_color_in  = 72'({$urandom(), $urandom(), $urandom()});
            out_ready     = ($urandom_range(1) == 1);
            cycle();
        end
        hit_valid_in = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        chk("rand_ovf", 72'(overflow), 72'(0));
        chk("rand_empty", 72'(count), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
